mem_arbiter_nport: RTL

- Byte-serial RAM access arbiter. Serves NCH independent request channels with round-robin fairness.
- Each channel can issue 1/2/4-byte reads or writes, with optional sign extension on reads.
- Sits between the fetch, load/store and any future DMA/debug masters and the single 8-bit RAM port.
- A flush input aborts pending or in-flight reads on selected channels and never disturbs writes.

---
 rtl/mem_arbiter_nport.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter_nport.sv
// Byte-serial RAM arbiter: NCH channels, round-robin grant, 1/2/4-byte reads/writes, read flush.
// Optional macro MEM_IO_STALL_EN holds writes to adr[17:16]==2'b11 while io_full_i is high.
module mem_arbiter_nport #(
    parameter int              NCH        = 2,
    parameter int              ADDR_W     = 32,
    parameter int              DAT_W      = 32,
    parameter logic [NCH-1:0]  FLUSH_MASK = 2'b01
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        req_i,
    input  logic [NCH-1:0]        we_i,
    input  logic [3*NCH-1:0]      len_i,
    input  logic [NCH-1:0]        sext_i,
    input  logic [ADDR_W*NCH-1:0] adr_i,
    input  logic [DAT_W*NCH-1:0]  dat_i,
    output logic [NCH-1:0]        done_o,
    output logic [DAT_W-1:0]      dat_o,
    output logic                  busy_o,
    input  logic                  flush_i,
    input  logic [7:0]            ram_dat_i,
    output logic [7:0]            ram_dat_o,
    output logic [ADDR_W-1:0]     ram_adr_o,
    output logic                  ram_wr_o,
    input  logic                  io_full_i
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, XFER, TAIL, DONE} state_t;
    state_t state, state_n;

    logic [NCH-1:0]    pend, ch_we, ch_sext;
    logic [2:0]        ch_len [NCH];
    logic [ADDR_W-1:0] ch_adr [NCH];
    logic [DAT_W-1:0]  ch_dat [NCH];

    logic [CW-1:0]     gnt, ptr, pick, idx;
    logic              pick_vld;
    logic [1:0]        cnt;
    logic [7:0]        rd_byte [4];
    logic [31:0]       rd_word;
    logic [ADDR_W-1:0] adr_hold;
    logic [NCH-1:0]    eligible, flush_kill, stall, take;

    logic              cur_we, cur_sext, abort;
    logic [2:0]        cur_len;
    logic [ADDR_W-1:0] cur_adr;
    logic [DAT_W-1:0]  cur_dat;

    function automatic logic [2:0] norm_len(input logic [2:0] l);
        case (l)
            3'd1:    return 3'd1;
            3'd2:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] l, input logic sx);
        case (l)
            3'd1:    return {{24{sx & w[7]}}, w[7:0]};
            3'd2:    return {{16{sx & w[15]}}, w[15:0]};
            default: return w;
        endcase
    endfunction

    assign cur_we   = ch_we[gnt];
    assign cur_sext = ch_sext[gnt];
    assign cur_len  = ch_len[gnt];
    assign cur_adr  = ch_adr[gnt];
    assign cur_dat  = ch_dat[gnt];
    assign rd_word  = {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};

    // Flush only ever targets reads on masked channels; writes always survive.
    assign flush_kill = flush_i ? (FLUSH_MASK & ~ch_we) : '0;
    assign abort      = flush_i && FLUSH_MASK[gnt] && !cur_we;

`ifdef MEM_IO_STALL_EN
    always_comb begin
        stall = '0;
        for (int i = 0; i < NCH; i++)
            stall[i] = io_full_i && ch_we[i] && (ch_adr[i][17:16] == 2'b11);
    end
`else
    logic io_full_unused;
    assign io_full_unused = io_full_i;
    assign stall = '0;
`endif

    assign eligible = pend & ~flush_kill & ~stall;

    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        // Walk downward so the channel closest to the pointer is the last (winning) assignment.
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = CW'((int'(ptr) + k) % NCH);
            if (eligible[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        take = '0;
        for (int i = 0; i < NCH; i++)
            take[i] = req_i[i]
                    && (!pend[i] || (state == DONE && gnt == CW'(i)))
                    && !(flush_i && FLUSH_MASK[i] && !we_i[i]);
    end

    always_comb begin
        state_n   = state;
        done_o    = '0;
        dat_o     = '0;
        busy_o    = 1'b0;
        ram_wr_o  = 1'b0;
        ram_dat_o = 8'h00;
        ram_adr_o = adr_hold;
        case (state)
            IDLE: if (pick_vld) state_n = XFER;
            XFER: begin
                busy_o    = 1'b1;
                ram_adr_o = cur_adr + ADDR_W'(cnt);
                if (cur_we) begin
                    ram_wr_o  = 1'b1;
                    ram_dat_o = cur_dat[{cnt, 3'b000} +: 8];
                end
                if (abort)
                    state_n = IDLE;
                else if ({1'b0, cnt} == cur_len - 3'd1)
                    state_n = cur_we ? DONE : TAIL;
            end
            TAIL: begin
                busy_o  = 1'b1;
                state_n = abort ? IDLE : DONE;
            end
            DONE: begin
                busy_o      = 1'b1;
                done_o[gnt] = 1'b1;
                dat_o       = cur_we ? '0 : extend(rd_word, cur_len, cur_sext);
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pend     <= '0;
            ptr      <= '0;
            gnt      <= '0;
            cnt      <= 2'd0;
            adr_hold <= '0;
        end else begin
            state <= state_n;
            for (int i = 0; i < NCH; i++) begin
                if (take[i])
                    pend[i] <= 1'b1;
                else if (flush_kill[i] || (state == DONE && gnt == CW'(i)))
                    pend[i] <= 1'b0;
            end
            case (state)
                IDLE: if (pick_vld) begin
                    gnt <= pick;
                    cnt <= 2'd0;
                end
                XFER: begin
                    cnt      <= cnt + 2'd1;
                    adr_hold <= ram_adr_o;
                end
                DONE: ptr <= (gnt == CW'(NCH - 1)) ? '0 : gnt + 1'b1;
                default: ;
            endcase
        end
    end

    // Request payload and read bytes: datapath only, no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (take[i]) begin
                ch_we[i]   <= we_i[i];
                ch_sext[i] <= sext_i[i];
                ch_len[i]  <= norm_len(len_i[3*i +: 3]);
                ch_adr[i]  <= adr_i[ADDR_W*i +: ADDR_W];
                ch_dat[i]  <= dat_i[DAT_W*i +: DAT_W];
            end
        end
        if (state == XFER && !cur_we && cnt != 2'd0)
            rd_byte[cnt - 2'd1] <= ram_dat_i;
        if (state == TAIL)
            rd_byte[2'(cur_len - 3'd1)] <= ram_dat_i;
    end

endmodule
